// File: rtl/sha256_axi_regs.sv
// AXI4-Lite register front end for a SHA-256 core: control pulses,
// status/done flag, single-word message buffer and sequential digest readout.
module sha256_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     msg_word,
    output logic                              msg_valid,
    input  logic                              msg_ready,
    output logic                              core_start,
    output logic                              core_init,
    input  logic                              core_busy,
    input  logic                              core_done,
    output logic [2:0]                        digest_idx,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     digest_word
);
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_MSG    = 2'd2;
    localparam logic [1:0] REG_DIGEST = 2'd3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                          r_bvalid, r_rvalid, r_done;
    logic [1:0]                    r_bresp;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata, r_msg_word, w_rdata;
    logic                          r_msg_valid, r_start, r_init;
    logic [2:0]                    r_idx;

    logic [1:0] w_wsel, w_rsel;
    logic       w_wr_acc, w_rd_acc, w_ctrl_wr, w_start, w_init;
    logic       w_msg_wr, w_msg_ok, w_stat_rd, w_dig_rd;
    logic       w_unused;

    assign w_wsel = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:C_S_AXI_ADDR_WIDTH-2];
    assign w_rsel = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:C_S_AXI_ADDR_WIDTH-2];

    // Ready is a same-cycle handshake; gating with reset keeps it low while held in reset.
    assign w_wr_acc  = s00_axi_awvalid & s00_axi_wvalid & ~r_bvalid & s00_axi_aresetn;
    assign w_rd_acc  = s00_axi_arvalid & ~r_rvalid & s00_axi_aresetn;
    assign w_ctrl_wr = w_wr_acc & (w_wsel == REG_CTRL) & s00_axi_wstrb[0];
    assign w_start   = w_ctrl_wr & s00_axi_wdata[0];
    assign w_init    = w_ctrl_wr & s00_axi_wdata[1];
    assign w_msg_wr  = w_wr_acc & (w_wsel == REG_MSG);
    // Buffer must be empty at accept time; a same-cycle drain does not free it early.
    assign w_msg_ok  = w_msg_wr & (&s00_axi_wstrb) & ~r_msg_valid;
    assign w_stat_rd = w_rd_acc & (w_rsel == REG_STATUS);
    assign w_dig_rd  = w_rd_acc & (w_rsel == REG_DIGEST);
    assign w_unused  = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-3:0],
                         s00_axi_araddr[C_S_AXI_ADDR_WIDTH-3:0]};

    assign s00_axi_awready = w_wr_acc;
    assign s00_axi_wready  = w_wr_acc;
    assign s00_axi_arready = w_rd_acc;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = r_bresp;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_rresp   = RESP_OKAY;
    assign msg_word        = r_msg_word;
    assign msg_valid       = r_msg_valid;
    assign core_start      = r_start;
    assign core_init       = r_init;
    assign digest_idx      = r_idx;

    // Read data selection at the accept cycle.
    always_comb begin
        w_rdata = '0;
        case (w_rsel)
            REG_STATUS: w_rdata = {{(C_S_AXI_DATA_WIDTH-3){1'b0}}, r_msg_valid, r_done, core_busy};
            REG_DIGEST: w_rdata = digest_word;
            default:    w_rdata = '0;
        endcase
    end

    // Write response channel; only rejected MSG writes return SLVERR.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_wr_acc) begin
            r_bvalid <= 1'b1;
            r_bresp  <= (w_msg_wr && !w_msg_ok) ? RESP_SLVERR : RESP_OKAY;
        end else if (s00_axi_bready) begin
            r_bvalid <= 1'b0;
        end
    end

    // Read response channel; data captured once and held until rready.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_rd_acc) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rdata;
        end else if (s00_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    // One-cycle control pulses to the core.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_start <= 1'b0;
            r_init  <= 1'b0;
        end else begin
            r_start <= w_start;
            r_init  <= w_init;
        end
    end

    // Sticky DONE flag; a coincident core_done wins over the clear.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn)           r_done <= 1'b0;
        else if (core_done)             r_done <= 1'b1;
        else if (w_stat_rd || w_start)  r_done <= 1'b0;
    end

    // Single-entry message buffer towards the core.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_msg_valid <= 1'b0;
            r_msg_word  <= '0;
        end else if (w_msg_ok) begin
            r_msg_valid <= 1'b1;
            r_msg_word  <= s00_axi_wdata;
        end else if (r_msg_valid && msg_ready) begin
            r_msg_valid <= 1'b0;
        end
    end

    // Digest word pointer: advances per DIGEST read, rewinds on START/INIT.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn)          r_idx <= 3'd0;
        else if (w_start || w_init)    r_idx <= 3'd0;
        else if (w_dig_rd)             r_idx <= r_idx + 3'd1;
    end
endmodule

// File: tb/tb_sha256_axi_regs.sv
// Randomized self-checking bench for sha256_axi_regs against a transaction-level model.
module tb_sha256_axi_regs;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata, msg_word, digest_word;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic        msg_valid, msg_ready, core_start, core_init, core_busy, core_done;
    logic [2:0]  digest_idx;

    always #5 clk = ~clk;

    // Core-side digest memory: word i reads as 0xA0 + i.
    assign digest_word = 32'hA0 + {29'd0, digest_idx};

    sha256_axi_regs dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .msg_word(msg_word), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .core_start(core_start), .core_init(core_init), .core_busy(core_busy), .core_done(core_done),
        .digest_idx(digest_idx), .digest_word(digest_word)
    );

    int n_chk = 0, n_fail = 0;

    // Transaction-level model state.
    bit          m_done, m_mv;
    logic [31:0] m_word;
    int          m_idx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus-level write; reports response and the control pulses seen at T+1.
    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input bit mr,
                      output logic [1:0] resp, output logic st, output logic in);
        int n = 0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        while (!(awready && wready) && n < 20) begin @(negedge clk); #1; n++; end
        chk("wr_accept", 32'(awready & wready), 32'd1);
        if (mr) msg_ready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; msg_ready = 1'b0;
        st = core_start; in = core_init;
        chk("bvalid_t1", 32'(bvalid), 32'd1);
        resp = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("bvalid_clr", 32'(bvalid), 32'd0);
        chk("pulse_width", 32'({core_start, core_init}), 32'd0);
    endtask

    // Bus-level read with optional rready stall and a core_done pulse at the accept cycle.
    task automatic rd(input logic [3:0] a, input int hold, input bit pd, output logic [31:0] data);
        int n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        #1;
        while (!arready && n < 20) begin @(negedge clk); #1; n++; end
        chk("rd_accept", 32'(arready), 32'd1);
        if (pd) core_done = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; core_done = 1'b0;
        chk("rvalid_t1", 32'(rvalid), 32'd1);
        chk("rresp", 32'(rresp), 32'd0);
        data = rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rdata_hold", rdata, data);
            chk("rvalid_hold", 32'(rvalid), 32'd1);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("rvalid_clr", 32'(rvalid), 32'd0);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input bit mr);
        logic [1:0] resp, exp_resp;
        logic st, in, exp_st, exp_in;
        exp_resp = 2'b00; exp_st = 1'b0; exp_in = 1'b0;
        case (a[3:2])
            2'd0: if (s[0]) begin
                exp_st = d[0]; exp_in = d[1];
                if (d[0]) m_done = 1'b0;
                if (d[0] || d[1]) m_idx = 0;
            end
            2'd2: begin
                if (m_mv || s != 4'hF) exp_resp = 2'b10;
                if (m_mv && mr) m_mv = 1'b0;
                else if (!m_mv && s == 4'hF) begin m_mv = 1'b1; m_word = d; end
            end
            default: ;
        endcase
        wr(a, d, s, mr, resp, st, in);
        chk("bresp", 32'(resp), 32'(exp_resp));
        chk("core_start", 32'(st), 32'(exp_st));
        chk("core_init", 32'(in), 32'(exp_in));
        chk("msg_valid", 32'(msg_valid), 32'(m_mv));
        if (m_mv) chk("msg_word", msg_word, m_word);
        chk("digest_idx", 32'(digest_idx), 32'(m_idx));
    endtask

    task automatic do_read(input logic [3:0] a, input int hold, input bit pd, input logic busy);
        logic [31:0] data, exp;
        core_busy = busy;
        exp = 32'd0;
        case (a[3:2])
            2'd1: begin exp = {29'd0, m_mv, m_done, busy}; m_done = 1'b0; end
            2'd3: begin exp = 32'hA0 + 32'(m_idx); m_idx = (m_idx + 1) % 8; end
            default: ;
        endcase
        if (pd) m_done = 1'b1;
        rd(a, hold, pd, data);
        chk($sformatf("rdata@%h", a), data, exp);
        chk("digest_idx", 32'(digest_idx), 32'(m_idx));
    endtask

    task automatic drain();
        if (m_mv) chk("msg_word_drain", msg_word, m_word);
        @(negedge clk); msg_ready = 1'b1;
        @(negedge clk); msg_ready = 1'b0;
        m_mv = 1'b0;
        chk("msg_valid_drain", 32'(msg_valid), 32'd0);
    endtask

    task automatic done_pulse();
        @(negedge clk); core_done = 1'b1;
        @(negedge clk); core_done = 1'b0;
        m_done = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        msg_ready = 1'b0; core_busy = 1'b0; core_done = 1'b0;
        m_done = 1'b0; m_mv = 1'b0; m_word = '0; m_idx = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'({awready, wready, arready}), 32'd0);
        chk("rst_valid", 32'({bvalid, rvalid, msg_valid}), 32'd0);
        chk("rst_resp", 32'({bresp, rresp}), 32'd0);
        chk("rst_data", rdata | msg_word, 32'd0);
        chk("rst_core", 32'({core_start, core_init, digest_idx}), 32'd0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        rst_n = 1'b1;

        // Message buffer: accept, reject while full, drain.
        do_write(4'h8, 32'h61626380, 4'hF, 1'b0);
        do_write(4'h8, 32'h00000000, 4'hF, 1'b0);
        drain();
        // Partial strobe is rejected.
        do_write(4'h9, 32'h12345678, 4'h3, 1'b0);
        // Same-cycle drain and new write: old word completes, new one rejected.
        do_write(4'h8, 32'hCAFEF00D, 4'hF, 1'b0);
        do_write(4'h8, 32'hDEADBEEF, 4'hF, 1'b1);

        // Digest readout with wrap and a stalled response.
        for (int i = 0; i < 9; i++) do_read(4'hC, 0, 1'b0, 1'b0);
        do_read(4'hC, 5, 1'b0, 1'b0);

        // START+INIT: both pulses, pointer rewinds; CTRL reads as zero.
        do_write(4'h0, 32'h3, 4'h1, 1'b0);
        do_read(4'h0, 0, 1'b0, 1'b0);

        // DONE flag set/clear and set-priority on coincident core_done.
        done_pulse();
        do_read(4'h4, 0, 1'b0, 1'b0);
        do_read(4'h4, 0, 1'b0, 1'b0);
        do_read(4'h4, 0, 1'b1, 1'b0);
        do_read(4'h4, 0, 1'b0, 1'b0);

        // Randomized mix of all register accesses.
        for (int k = 0; k < 250; k++) begin
            case ($urandom_range(0, 6))
                0: do_write(4'($urandom_range(0, 3)), 32'($urandom_range(0, 3)),
                            4'($urandom_range(0, 15)), 1'b0);
                1: do_write(4'h8, $urandom, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
                            ($urandom_range(0, 3) == 0));
                2: do_write(($urandom_range(0, 1) == 1) ? 4'h4 : 4'hC, $urandom, 4'hF, 1'b0);
                3, 4: do_read(4'($urandom_range(0, 15)), $urandom_range(0, 2),
                              ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
                5: drain();
                default: done_pulse();
            endcase
        end

        // Reset in the middle of a write response with a pending message and DONE set.
        if (!m_mv) do_write(4'h8, 32'h0BADF00D, 4'hF, 1'b0);
        done_pulse();
        @(negedge clk);
        awaddr = 4'h4; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid_pre_rst", 32'(bvalid), 32'd1);
        chk("msg_valid_pre_rst", 32'(msg_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("bvalid_in_rst", 32'(bvalid), 32'd0);
        chk("msg_valid_in_rst", 32'(msg_valid), 32'd0);
        chk("msg_word_in_rst", msg_word, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_done = 1'b0; m_mv = 1'b0; m_idx = 0;
        do_write(4'h0, 32'h0, 4'h1, 1'b0);
        do_write(4'h8, 32'h61626380, 4'hF, 1'b0);
        do_read(4'h4, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
